// File: rtl/reg_cmd_exec.sv
// Command executor: decodes {op, address, data} words against a small register file
// and answers each executed command on a valid/ready response channel. Optional INCR: REG_CMD_INCR_EN.
module reg_cmd_exec #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned OP_W     = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [OP_W+ADDR_W+DATA_W-1:0]   cmd_word,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [OP_W-1:0]                 rsp_op,
    output logic [DATA_W-1:0]               rsp_data,
    output logic                            rsp_err,
    output logic                            busy
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_CLR  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [OP_W-1:0] OP_WRITE = OP_W'(8'h01);
    localparam logic [OP_W-1:0] OP_READ  = OP_W'(8'h02);
`ifdef REG_CMD_INCR_EN
    localparam logic [OP_W-1:0] OP_INCR  = OP_W'(8'h03);
`endif
    localparam logic [OP_W-1:0] OP_CLEAR = OP_W'(8'h04);
    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(8'hFF);

    logic [1:0]        state, state_n;
    logic [OP_W-1:0]   lat_op, lat_op_n;
    logic [ADDR_W-1:0] lat_addr, lat_addr_n;
    logic [DATA_W-1:0] lat_data, lat_data_n;
    logic [IDX_W-1:0]  walk, walk_n;
    logic              rsp_valid_n, rsp_err_n;
    logic [OP_W-1:0]   rsp_op_n;
    logic [DATA_W-1:0] rsp_data_n;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [OP_W-1:0]   cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              addr_ok;
    logic [IDX_W-1:0]  lat_idx;

    assign cmd_op   = cmd_word[OP_W+ADDR_W+DATA_W-1 -: OP_W];
    assign cmd_addr = cmd_word[ADDR_W+DATA_W-1 -: ADDR_W];
    assign cmd_data = cmd_word[DATA_W-1:0];
    assign addr_ok  = (lat_addr < ADDR_W'(NUM_REGS));
    assign lat_idx  = lat_addr[IDX_W-1:0];

    // Next-state, response and register-file write decode
    always_comb begin
        state_n     = state;
        lat_op_n    = lat_op;
        lat_addr_n  = lat_addr;
        lat_data_n  = lat_data;
        walk_n      = walk;
        rsp_valid_n = rsp_valid;
        rsp_op_n    = rsp_op;
        rsp_data_n  = rsp_data;
        rsp_err_n   = rsp_err;
        wr_en       = 1'b0;
        wr_idx      = lat_idx;
        wr_data     = '0;

        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_op != OP_NOP) begin
                    if (cmd_op == OP_CLEAR) begin
                        state_n = S_CLR;
                        walk_n  = '0;
                    end else begin
                        state_n    = S_EXEC;
                        lat_op_n   = cmd_op;
                        lat_addr_n = cmd_addr;
                        lat_data_n = cmd_data;
                    end
                end
            end
            S_EXEC: begin
                state_n     = S_RESP;
                rsp_valid_n = 1'b1;
                rsp_op_n    = lat_op;
                rsp_data_n  = '0;
                rsp_err_n   = 1'b1;
                case (lat_op)
                    OP_WRITE: if (addr_ok) begin
                        wr_en      = 1'b1;
                        wr_data    = lat_data;
                        rsp_data_n = lat_data;
                        rsp_err_n  = 1'b0;
                    end
                    OP_READ: if (addr_ok) begin
                        rsp_data_n = regs[lat_idx];
                        rsp_err_n  = 1'b0;
                    end
`ifdef REG_CMD_INCR_EN
                    // Wraps modulo 2^DATA_W; the carry is dropped
                    OP_INCR: if (addr_ok) begin
                        wr_en      = 1'b1;
                        wr_data    = regs[lat_idx] + lat_data;
                        rsp_data_n = wr_data;
                        rsp_err_n  = 1'b0;
                    end
`endif
                    default: ;
                endcase
            end
            S_CLR: begin
                wr_en   = 1'b1;
                wr_idx  = walk;
                wr_data = '0;
                walk_n  = walk + IDX_W'(1);
                if (walk == IDX_W'(NUM_REGS - 1)) begin
                    state_n     = S_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_op_n    = OP_CLEAR;
                    rsp_data_n  = '0;
                    rsp_err_n   = 1'b0;
                end
            end
            default: begin
                if (rsp_ready) begin
                    state_n     = S_IDLE;
                    rsp_valid_n = 1'b0;
                end
            end
        endcase
    end

    // State, registered outputs and register file
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            lat_op    <= '0;
            lat_addr  <= '0;
            lat_data  <= '0;
            walk      <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_op    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
        end else begin
            state     <= state_n;
            lat_op    <= lat_op_n;
            lat_addr  <= lat_addr_n;
            lat_data  <= lat_data_n;
            walk      <= walk_n;
            cmd_ready <= (state_n == S_IDLE);
            busy      <= (state_n != S_IDLE);
            rsp_valid <= rsp_valid_n;
            rsp_op    <= rsp_op_n;
            rsp_data  <= rsp_data_n;
            rsp_err   <= rsp_err_n;
            if (wr_en) regs[wr_idx] <= wr_data;
        end
    end

endmodule

// File: doc/reg_cmd_exec.md
Name: reg_cmd_exec

Overview:
- Downstream consumer of the 32-bit control word {op_code[31:24], address[23:16], data[15:0]} produced by the command-capture stage.
- Decodes each command and executes it against a local NUM_REGS x DATA_W register file.
- Returns one response per executed command over a valid/ready channel.
- Sits between command capture and the bus/bench response monitor.

Parameters:
- NUM_REGS, 8, number of registers in the file; an address is valid when address < NUM_REGS.
- DATA_W, 16, register and data width.
- ADDR_W, 8, command address field width.
- OP_W, 8, command op-code field width.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  cmd_word is valid this cycle.
- cmd_ready  output  1  block accepts a command this cycle.
- cmd_word  input  32  [31:24] op_code, [23:16] address, [15:0] data.
- rsp_valid  output  1  response fields are valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_op  output  8  op_code of the command being answered.
- rsp_data  output  16  result data.
- rsp_err  output  1  command failed: bad address or unknown op.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - Every register in the file is 0x0000.
  - FSM is in IDLE.
  - cmd_ready=1, rsp_valid=0, rsp_op=0x00, rsp_data=0x0000, rsp_err=0, busy=0.
- Reset mid-operation (EXEC, CLEAR walk or RESP): abandons the command; no response is produced; same reset state as above.
- Op codes: 0x01 WRITE, 0x02 READ, 0x03 INCR (optional, see below), 0x04 CLEAR, 0xFF NOP. The upstream stage's reset value is 0xFF, so it is always a NOP.
- Handshake: a command is accepted on a cycle where cmd_valid & cmd_ready; cmd_ready=1 only in IDLE.
- FSM states: IDLE, EXEC, CLR, RESP.
  - IDLE: on accept of NOP -> stay in IDLE; no response, no state change.
  - IDLE: on accept of CLEAR with valid op -> CLR.
  - IDLE: on accept of any other op -> EXEC; op, address and data are latched.
  - EXEC (1 cycle) -> RESP. Updates the file, loads response fields, asserts rsp_valid on entry to RESP.
  - CLR: writes 0x0000 to register index k for k = 0..NUM_REGS-1, one register per cycle, driven by a 3-bit walk counter, NUM_REGS cycles total -> RESP.
  - RESP: holds rsp_valid and all response fields stable until rsp_ready. On the cycle rsp_valid & rsp_ready -> IDLE; cmd_ready=1 on the next cycle.
- Latency:
  - Accept to rsp_valid: 2 cycles for WRITE, READ and INCR.
  - Accept to rsp_valid: NUM_REGS+1 cycles for CLEAR.
  - Throughput: at most one command per 3 cycles.
- Per-op results (address[2:0] indexes the file):
  - WRITE: reg[addr] <= data; rsp_data = data.
  - READ: rsp_data = reg[addr]; the file is unchanged.
  - INCR: reg[addr] <= reg[addr] + data, modulo 2^16 (0xFFFF + 0x0001 = 0x0000, no carry out); rsp_data = new value.
  - CLEAR: the address field is ignored; rsp_data = 0x0000.
- Error cases:
  - address >= NUM_REGS on WRITE, READ or INCR: no file update; rsp_err=1; rsp_data=0x0000.
  - Unknown op code: goes through EXEC with no file update; rsp_err=1; rsp_data=0x0000; rsp_op echoes the op code.
- rsp_ready held high: the response still lasts at least 1 cycle; no command is accepted in the same cycle the response completes.
- cmd_word is ignored whenever cmd_ready=0.

Optional Feature:
- Macro: REG_CMD_INCR_EN.
- Defined: op 0x03 performs INCR as specified above.
- Undefined: 0x03 is an unknown op code; rsp_err=1 and the file is unchanged. No adder is synthesized.

Test Plan:
1. Reset, then WRITE addr 0x02 data 0xA5A5, then READ 0x02 -> two responses: {op 0x01, data 0xA5A5, err 0} then {op 0x02, data 0xA5A5, err 0}; each rsp_valid 2 cycles after accept.
2. WRITE 0x07 0xFFFF, INCR 0x07 0x0001, READ 0x07 -> INCR response data 0x0000; READ data 0x0000. Without the macro, INCR gives err=1 and READ returns 0xFFFF.
3. READ addr 0x08 and op 0x55 -> both give err=1 and data 0x0000; a following READ 0x00 returns the prior value.
4. Fill all 8 registers, then CLEAR -> rsp_valid 9 cycles after accept; READ of any address returns 0x0000.
5. Hold rsp_ready=0 for 5 cycles after a READ -> rsp_valid and fields stay stable; cmd_ready stays 0; a command presented meanwhile is not accepted.
6. Assert reset during the CLR walk at k=3 -> no response; all registers read 0x0000; cmd_ready=1 in the cycle after reset deasserts. Separately, a cmd_word of 0xFFFFFFFF -> no response and busy stays 0.
